scrambler_framer: RTL
=====================

SCRAMBLER_FRAMER -- requirements
Module: scrambler_framer

Interface
REQ-001 SHALL have parameter W, default 1: bits per beat; legal values 1, 2, 3, 6.
REQ-002 SHALL have parameter HDR_BITS, default 24: unscrambled SIGNAL-field bits; a multiple of W.
REQ-003 SHALL have parameter SVC_BITS, default 16: SERVICE bits; a multiple of W.
REQ-004 SHALL have port Clk, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port En, input, 1 bit: start pulse, sampled only in IDLE.
REQ-007 SHALL have port Seed, input, 7 bits: LFSR seed, captured with En.
REQ-008 SHALL have port Length, input, 12 bits: payload bit count (multiple of W), captured with En.
REQ-009 SHALL have port Pad_bits, input, 12 bits: pad bit count (multiple of W), captured with En.
REQ-010 SHALL have ports In_valid (input, 1), In_data (input, W) and In_ready (output, 1): upstream bit stream.
REQ-011 SHALL have ports Out_valid (output, 1), Out_data (output, W), Out_last (output, 1) and Out_ready (input, 1): downstream stream.
REQ-012 SHALL have port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 Bit order: bit [0] of In_data and of Out_data is the earliest bit in time.
REQ-014 Transfer rule: a beat transfers on an edge where valid and ready are both high.
- A beat is accepted internally when Out_ready is high or Out_valid is low.
- Out_data and Out_valid are registered; latency is 1 cycle from accept to Out_valid.
REQ-015 Out_valid and Out_data SHALL stay stable while Out_valid is high and Out_ready is low.
REQ-016 States are IDLE, HDR, SVC, DATA, TAIL, PAD, with a beat counter in each. Transitions:
- IDLE->HDR on En.
- HDR->SVC after HDR_BITS/W beats.
- SVC->DATA after SVC_BITS/W beats.
- DATA->TAIL after Length/W beats.
- TAIL->PAD after 6/W beats.
- PAD->IDLE after Pad_bits/W beats.
- A state whose count is 0 is skipped in the same cycle.
REQ-017 In_ready SHALL be high only in HDR and DATA while a beat can be accepted.
- HDR and DATA advance only on an input transfer.
- SVC, TAIL and PAD generate beats internally and ignore In_valid.
REQ-018 LFSR: 7 bits, polynomial x^7+x^4+1.
- Scramble bit = s[6]^s[3]; the state shifts left with this bit entering s[0].
- W bits are produced per beat (unrolled).
- Seed is loaded on En; Seed==0 loads 7'h7F instead.
REQ-019 HDR: Out_data = In_data, LFSR held.
REQ-020 SVC: Out_data = zeros XOR scramble bits, LFSR advances.
REQ-021 DATA: Out_data = In_data XOR scramble bits, LFSR advances.
REQ-022 TAIL: Out_data = 0 (forced), LFSR advances.
REQ-023 PAD: Out_data = zeros XOR scramble bits, LFSR advances.
REQ-024 Out_last SHALL be high with the final beat of the frame and only then.
- If Pad_bits==0, the final beat is the last TAIL beat.
REQ-025 En while Busy SHALL be ignored; a new En is accepted in the cycle after the last beat is accepted.
REQ-026 Length==0 SHALL go SVC->TAIL with no In_ready pulses in DATA.
REQ-027 Counters SHALL be 12 bits and SHALL NOT wrap within a frame.

Reset
REQ-028 While Reset_n is low:
- State = IDLE, counters = 0, LFSR = 7'h7F.
- Out_valid = 0, Out_data = 0, Out_last = 0, In_ready = 0, Busy = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; no Out_last is produced.
REQ-030 After Reset_n deasserts, the block SHALL wait for a fresh En.

Verification
REQ-031 W=1, Seed=7'h7F, Length=8, data all zero, Out_ready=1:
- First 8 SVC bits out = 0,0,0,0,1,1,1,0.
- The 24 HDR bits are echoed unchanged.
REQ-032 W=1, same frame: the 6 TAIL bits are all 0.
- Out_last fires on the last PAD bit: beat 24+16+8+6+Pad_bits.
REQ-033 Out_ready toggled 1,0,0,1 in DATA:
- Out_data holds during stall; In_ready is low during stall.
- No bit is lost or duplicated versus the golden model.
REQ-034 Seed=0: output matches the Seed=7'h7F run bit-for-bit.
REQ-035 W=3, Length=0, Pad_bits=0:
- No In_ready pulses after HDR.
- Out_last fires on the second TAIL beat.
REQ-036 Reset_n pulsed low at DATA beat 3:
- All outputs 0 within the same cycle.
- Busy=0; the next En produces a complete correct frame.

Source files
------------

// File: rtl/scrambler_framer.sv
// scrambler_framer: frame builder for a W-bit-per-beat serial stream.
// A frame is an unscrambled header echoed from the input, then scrambled
// SERVICE bits, then scrambled payload from the input, then six forced-zero
// tail bits, then scrambled pad bits. The scrambler is a 7-bit LFSR
// (x^7 + x^4 + 1), unrolled to produce W bits per beat. Bit [0] of a beat is
// the earliest bit in time.
//
// state | meaning
// IDLE  | waiting for En; Seed/Length/Pad_bits are captured on En
// HDR   | echo header beats from the input, LFSR held
// SVC   | emit scrambled zero beats (SERVICE field)
// DATA  | emit input beats XOR scramble bits
// TAIL  | emit forced-zero beats, LFSR still advances
// PAD   | emit scrambled zero beats; the last one carries Out_last

module scrambler_framer #(
    parameter int W        = 1,
    parameter int HDR_BITS = 24,
    parameter int SVC_BITS = 16
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         En,
    input  logic [6:0]   Seed,
    input  logic [11:0]  Length,
    input  logic [11:0]  Pad_bits,
    input  logic         In_valid,
    input  logic [W-1:0] In_data,
    output logic         In_ready,
    output logic         Out_valid,
    output logic [W-1:0] Out_data,
    output logic         Out_last,
    input  logic         Out_ready,
    output logic         Busy
);

    typedef enum logic [2:0] {IDLE, HDR, SVC, DATA, TAIL, PAD} state_t;

    typedef struct packed {
        state_t      st;
        logic [11:0] cnt;
    } seek_t;

    localparam logic [11:0] HDR_CNT  = 12'(HDR_BITS / W);
    localparam logic [11:0] SVC_CNT  = 12'(SVC_BITS / W);
    localparam logic [11:0] TAIL_CNT = 12'(6 / W);
    localparam logic [6:0]  LFSR_INIT = 7'h7F;

    state_t         state_q;
    logic [11:0]    cnt_q;
    logic [11:0]    len_q;
    logic [11:0]    pad_q;
    logic [6:0]     lfsr_q;
    logic [6:0]     lfsr_d;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;
    logic           out_last_q;

    logic           accept;
    logic           in_phase;
    logic           gen_phase;
    logic           beat;
    logic           final_beat;
    logic [W-1:0]   scr_bits;
    logic [W-1:0]   beat_data;
    logic [6:0]     lfsr_w;
    logic           fb;
    seek_t          nxt;
    seek_t          start;

    // Starting at start_at, return the first state with a non-zero beat count.
    // TAIL always has a non-zero count, so every frame ends through TAIL.
    function automatic seek_t seek(input state_t start_at,
                                   input logic [11:0] len_b,
                                   input logic [11:0] pad_b);
        seek_t  r;
        state_t s;
        s     = start_at;
        r.st  = IDLE;
        r.cnt = '0;
        if (s == HDR) begin
            if (HDR_CNT != 12'd0) begin
                r.st = HDR; r.cnt = HDR_CNT; return r;
            end
            s = SVC;
        end
        if (s == SVC) begin
            if (SVC_CNT != 12'd0) begin
                r.st = SVC; r.cnt = SVC_CNT; return r;
            end
            s = DATA;
        end
        if (s == DATA) begin
            if (len_b != 12'd0) begin
                r.st = DATA; r.cnt = len_b; return r;
            end
            s = TAIL;
        end
        if (s == TAIL) begin
            r.st = TAIL; r.cnt = TAIL_CNT; return r;
        end
        if (s == PAD) begin
            if (pad_b != 12'd0) begin
                r.st = PAD; r.cnt = pad_b; return r;
            end
        end
        return r;
    endfunction

    // The output register can take a new beat when empty or being drained.
    always_comb begin
        accept     = Out_ready || !out_valid_q;
        in_phase   = (state_q == HDR) || (state_q == DATA);
        gen_phase  = (state_q == SVC) || (state_q == TAIL) || (state_q == PAD);
        In_ready   = in_phase && accept;
        beat       = in_phase ? (In_valid && accept) : (gen_phase && accept);
        final_beat = (cnt_q == 12'd1) &&
                     ((state_q == PAD) || ((state_q == TAIL) && (pad_q == 12'd0)));
    end

    // Unrolled LFSR: W scramble bits for this beat and the state after them.
    always_comb begin
        lfsr_w   = lfsr_q;
        scr_bits = '0;
        fb       = 1'b0;
        for (int i = 0; i < W; i++) begin
            fb          = lfsr_w[6] ^ lfsr_w[3];
            scr_bits[i] = fb;
            lfsr_w      = {lfsr_w[5:0], fb};
        end
        lfsr_d = lfsr_w;
    end

    // Per-state content of the beat being produced.
    always_comb begin
        beat_data = '0;
        case (state_q)
            HDR:      beat_data = In_data;
            SVC, PAD: beat_data = scr_bits;
            DATA:     beat_data = In_data ^ scr_bits;
            default:  beat_data = '0;
        endcase
    end

    // Successor of the current state (zero-count states skipped) and the
    // entry state for a frame started by En.
    always_comb begin
        case (state_q)
            HDR:     nxt = seek(SVC,  len_q, pad_q);
            SVC:     nxt = seek(DATA, len_q, pad_q);
            DATA:    nxt = seek(TAIL, len_q, pad_q);
            TAIL:    nxt = seek(PAD,  len_q, pad_q);
            default: nxt = seek(IDLE, len_q, pad_q);
        endcase
        start = seek(HDR, 12'(Length / W), 12'(Pad_bits / W));
    end

    // Frame FSM with beat down-counter, LFSR and registered output stage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            pad_q       <= '0;
            lfsr_q      <= LFSR_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (beat) begin
                out_valid_q <= 1'b1;
                out_data_q  <= beat_data;
                out_last_q  <= final_beat;
            end else if (Out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (En) begin
                        len_q   <= 12'(Length / W);
                        pad_q   <= 12'(Pad_bits / W);
                        lfsr_q  <= (Seed == 7'd0) ? LFSR_INIT : Seed;
                        state_q <= start.st;
                        cnt_q   <= start.cnt;
                    end
                end
                default: begin
                    if (beat) begin
                        if (state_q != HDR) begin
                            lfsr_q <= lfsr_d;
                        end
                        if (cnt_q == 12'd1) begin
                            state_q <= nxt.st;
                            cnt_q   <= nxt.cnt;
                        end else begin
                            cnt_q <= cnt_q - 12'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign Out_valid = out_valid_q;
    assign Out_data  = out_data_q;
    assign Out_last  = out_last_q;
    assign Busy      = (state_q != IDLE);

endmodule
